count_ones: RTL and testbench

- Registered population counter: counts the '1' bits in a `from`-bit input word and presents the total on a `downto`-bit output.
- Utility block for the ADC datapath (adcv), e.g. thermometer/bit-vector to binary magnitude conversion.
- One clock; reset is synchronous and active-high.

---
 rtl/count_ones_pkg.sv | 12 +
 rtl/count_ones_popcount_tree.sv | 38 +++
 rtl/count_ones.sv | 40 ++++
 tb/tb_count_ones.sv | 110 +++++++++++
 4 files changed

// File: rtl/count_ones_pkg.sv
// Shared constants and width helpers for the count_ones population counter.
package count_ones_pkg;

   localparam int FROM_DEF   = 16;
   localparam int DOWNTO_DEF = 4;

   // Width needed to hold an exact count of n bits (0..n inclusive).
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/count_ones_popcount_tree.sv
// Combinational balanced adder tree; splits the word in halves and sums the
// two exact partial counts. Odd widths push the spare bit into the upper half.
module popcount_tree
   import count_ones_pkg::*;
#(
   parameter  int W  = 16,
   localparam int SW = cnt_width(W)
) (
   input  logic [W-1:0]  bits_i,
   output logic [SW-1:0] sum_o
);

   if (W == 1) begin : g_leaf
      assign sum_o = bits_i;
   end else begin : g_node
      localparam int LW  = W / 2;
      localparam int RW  = W - LW;
      localparam int LSW = cnt_width(LW);
      localparam int RSW = cnt_width(RW);

      logic [LSW-1:0] lo_sum;
      logic [RSW-1:0] hi_sum;

      popcount_tree #(.W(LW)) u_lo (
         .bits_i (bits_i[LW-1:0]),
         .sum_o  (lo_sum)
      );

      popcount_tree #(.W(RW)) u_hi (
         .bits_i (bits_i[W-1:LW]),
         .sum_o  (hi_sum)
      );

      // SW always covers LW+RW, so this add cannot overflow.
      assign sum_o = SW'(lo_sum) + SW'(hi_sum);
   end

endmodule

// File: rtl/count_ones.sv
// Registered population counter: exact popcount of bin, saturated to the
// output width, presented one clock after sampling.
module count_ones
   import count_ones_pkg::*;
#(
   parameter int from   = FROM_DEF,
   parameter int downto = DOWNTO_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [from-1:0]   bin,
   output logic [downto-1:0] count
);

   localparam int SW = cnt_width(from);

   logic [SW-1:0]     sum;
   logic [downto-1:0] count_d;
   logic [downto-1:0] count_q;

   popcount_tree #(.W(from)) u_tree (
      .bits_i (bin),
      .sum_o  (sum)
   );

   if (SW > downto) begin : g_sat
      localparam logic [SW-1:0] MAX = SW'({downto{1'b1}});
      assign count_d = (sum > MAX) ? {downto{1'b1}} : sum[downto-1:0];
   end else begin : g_ext
      assign count_d = downto'(sum);
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_count_ones.sv
// Directed and random checks of count_ones in three width configurations.
module tb_count_ones;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bin_a = '0;
   logic [15:0] bin_b = '0;
   logic [6:0]  bin_c = '0;
   logic [3:0]  cnt_a;
   logic [4:0]  cnt_b;
   logic [2:0]  cnt_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   count_ones #(.from(16), .downto(4)) u_a (.clk(clk), .reset(reset), .bin(bin_a), .count(cnt_a));
   count_ones #(.from(16), .downto(5)) u_b (.clk(clk), .reset(reset), .bin(bin_b), .count(cnt_b));
   count_ones #(.from(7),  .downto(3)) u_c (.clk(clk), .reset(reset), .bin(bin_c), .count(cnt_c));

   localparam logic [15:0] DV [9] = '{16'h007F, 16'h0AAA, 16'h08E4, 16'h0920, 16'h0000,
                                      16'hFFFF, 16'h7FFF, 16'hFFFC, 16'h8000};
   localparam int          DE [9] = '{7, 6, 5, 3, 0, 15, 15, 14, 1};

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int ref_cnt(input logic [15:0] v, input int w, input int dw);
      int n = 0;
      for (int i = 0; i < w; i++) n += int'(v[i]);
      if (n > (1 << dw) - 1) n = (1 << dw) - 1;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] w;
      int          exp_a;

      // reset holds count at zero regardless of input
      bin_a = 16'h00FF; bin_b = 16'hFFFF; bin_c = 7'h7F;
      tick();
      chk("rst0_a", cnt_a, 0);
      chk("rst0_b", cnt_b, 0);
      tick();
      chk("rst1_a", cnt_a, 0);
      chk("rst1_c", cnt_c, 0);
      reset = 1'b0;
      tick();
      chk("rel_a", cnt_a, 8);
      chk("rel_b_nosat", cnt_b, 16);
      chk("rel_c_full", cnt_c, 7);

      // directed words including saturation boundaries
      for (int i = 0; i < 9; i++) begin
         bin_a = DV[i];
         tick();
         chk($sformatf("dir%0d_%h", i, DV[i]), cnt_a, DE[i]);
      end

      // back-to-back: each result appears exactly one edge later
      bin_a = 16'h0001; tick(); chk("b2b_1", cnt_a, 1);
      bin_a = 16'h0003; tick(); chk("b2b_2", cnt_a, 2);
      bin_a = 16'h0007; tick(); chk("b2b_3", cnt_a, 3);
      bin_a = 16'h0000; #3;     chk("b2b_hold", cnt_a, 3);
      tick();                   chk("b2b_0", cnt_a, 0);

      // mid-stream reset discards the pending sample
      for (int i = 0; i < 4; i++) begin
         w = 16'($urandom); bin_a = w;
         tick();
         chk("stream_pre", cnt_a, ref_cnt(w, 16, 4));
      end
      reset = 1'b1; bin_a = 16'hFFFF;
      tick();
      chk("mid_rst", cnt_a, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w = 16'($urandom); bin_a = w;
         exp_a = ref_cnt(w, 16, 4);
         tick();
         chk("stream_post", cnt_a, exp_a);
      end

      // random sweep across all three configurations
      for (int i = 0; i < 1000; i++) begin
         bin_a = 16'($urandom);
         bin_b = 16'($urandom);
         bin_c = 7'($urandom);
         tick();
         chk("rnd_16_4", cnt_a, ref_cnt(bin_a, 16, 4));
         chk("rnd_16_5", cnt_b, ref_cnt(bin_b, 16, 5));
         chk("rnd_7_3",  cnt_c, ref_cnt({9'd0, bin_c}, 7, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
